// File: rtl/instr_fetch.sv
// instr_fetch: IF stage; holds PC, reads a 1-cycle-latency instruction memory
// and registers each returned word with its PC into the IF/ID boundary.
// Ports:
//   i_clk, i_nRst              clock, synchronous active-low reset
//   i_stall                    decode cannot accept; outputs hold
//   i_redirect, i_target       taken branch/jump: flush, refetch at i_target
//   o_imAddr, o_imRdEn         instruction memory address / read strobe
//   i_imData                   memory data, valid the cycle after o_imRdEn
//   o_instr, o_pc, o_pcPlus1   instruction to decode with its PC and PC+1
//   o_valid, o_hlt             o_instr is real / fetch halted
module instr_fetch #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
  input  logic        i_clk,
  input  logic        i_nRst,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [15:0] i_target,
  output logic [15:0] o_imAddr,
  output logic        o_imRdEn,
  input  logic [15:0] i_imData,
  output logic [15:0] o_instr,
  output logic [15:0] o_pc,
  output logic [15:0] o_pcPlus1,
  output logic        o_valid,
  output logic        o_hlt
);

  logic [15:0] pc_q, pc_d;
  logic        req_valid_q, req_valid_d;
  logic [15:0] req_pc_q, req_pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic [15:0] skid_instr_q, skid_instr_d;
  logic [15:0] skid_pc_q, skid_pc_d;
  logic        valid_q, valid_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] out_pc_q, out_pc_d;
  logic        halted_q, halted_d;

  logic issue;
  logic resp_ok;
  logic resp_hlt;

  // Issue never looks at i_imData, so no data-to-strobe path exists.
  assign issue = !halted_q && !i_stall && !skid_valid_q && !i_redirect;

  // A response returning after halt (or on a flush) is dropped.
  assign resp_ok  = req_valid_q && !halted_q && !i_redirect;
  assign resp_hlt = resp_ok && (i_imData[15:12] == HLT_OPCODE);

  always_comb begin
    pc_d         = pc_q;
    req_valid_d  = req_valid_q;
    req_pc_d     = req_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    valid_d      = valid_q;
    instr_d      = instr_q;
    out_pc_d     = out_pc_q;
    halted_d     = halted_q;

    if (i_redirect) begin
      pc_d         = i_target;
      req_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
      valid_d      = 1'b0;
      halted_d     = 1'b0;
    end else begin
      req_valid_d = issue;
      if (issue) begin
        req_pc_d = pc_q;
        pc_d     = pc_q + 16'd1;
      end

      if (!i_stall) begin
        // Skid and a pending response are never both present:
        // nothing is issued while stalled or while the skid is full.
        if (skid_valid_q) begin
          valid_d      = 1'b1;
          instr_d      = skid_instr_q;
          out_pc_d     = skid_pc_q;
          skid_valid_d = 1'b0;
        end else if (resp_ok) begin
          valid_d  = 1'b1;
          instr_d  = i_imData;
          out_pc_d = req_pc_q;
        end else begin
          valid_d = 1'b0;
        end
      end else if (resp_ok) begin
        skid_valid_d = 1'b1;
        skid_instr_d = i_imData;
        skid_pc_d    = req_pc_q;
      end

      if (resp_hlt) halted_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_nRst) begin
      pc_q         <= RESET_PC;
      req_valid_q  <= 1'b0;
      req_pc_q     <= 16'h0000;
      skid_valid_q <= 1'b0;
      skid_instr_q <= 16'h0000;
      skid_pc_q    <= 16'h0000;
      valid_q      <= 1'b0;
      instr_q      <= 16'h0000;
      out_pc_q     <= 16'h0000;
      halted_q     <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      req_valid_q  <= req_valid_d;
      req_pc_q     <= req_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      out_pc_q     <= out_pc_d;
      halted_q     <= halted_d;
    end
  end

  assign o_imAddr  = pc_q;
  assign o_imRdEn  = issue;
  assign o_instr   = instr_q;
  assign o_pc      = out_pc_q;
  assign o_pcPlus1 = out_pc_q + 16'd1;
  assign o_valid   = valid_q;
  assign o_hlt     = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed + lightly randomised stimulus for instr_fetch,
// checked every cycle against a queue-based fetch model and literal values.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [15:0] target;

  logic [15:0] im_addr, im_data, instr, pc, pcp1;
  logic        im_rd, valid, hlt;
  logic [15:0] im_addr2, im_data2, instr2, pc2, pcp12;
  logic        im_rd2, valid2, hlt2;

  logic [15:0] mem [0:65535];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  instr_fetch dut (
    .i_clk(clk), .i_nRst(rst_n), .i_stall(stall),
    .i_redirect(redirect), .i_target(target),
    .o_imAddr(im_addr), .o_imRdEn(im_rd), .i_imData(im_data),
    .o_instr(instr), .o_pc(pc), .o_pcPlus1(pcp1),
    .o_valid(valid), .o_hlt(hlt)
  );

  instr_fetch #(.RESET_PC(16'hFFFE)) dut2 (
    .i_clk(clk), .i_nRst(rst_n), .i_stall(1'b0),
    .i_redirect(1'b0), .i_target(16'h0000),
    .o_imAddr(im_addr2), .o_imRdEn(im_rd2), .i_imData(im_data2),
    .o_instr(instr2), .o_pc(pc2), .o_pcPlus1(pcp12),
    .o_valid(valid2), .o_hlt(hlt2)
  );

  always @(posedge clk) begin
    if (im_rd) im_data <= mem[im_addr];
    if (im_rd2) im_data2 <= mem[im_addr2];
  end

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Model: a fetch is one in-flight request, words waiting for decode sit
  // in a queue, and the decode-side register shows the last word handed over.
  bit          m_on = 0;
  logic [15:0] m_pc, m_req_pc, m_req_in;
  bit          m_req, m_halted, m_out_v;
  logic [15:0] m_out_pc, m_out_in;
  logic [15:0] q_pc [$];
  logic [15:0] q_in [$];
  bit          m_iss, m_arr;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_on = 1;
      m_pc = 16'h0000;
      m_req = 0;
      m_halted = 0;
      m_out_v = 0;
      q_pc.delete();
      q_in.delete();
    end else if (redirect) begin
      m_pc = target;
      m_req = 0;
      m_halted = 0;
      m_out_v = 0;
      q_pc.delete();
      q_in.delete();
    end else begin
      m_iss = !m_halted && !stall && q_pc.size() == 0;
      m_arr = m_req && !m_halted;
      if (!stall) begin
        if (q_pc.size() > 0) begin
          m_out_v = 1;
          m_out_pc = q_pc.pop_front();
          m_out_in = q_in.pop_front();
        end else if (m_arr) begin
          m_out_v = 1;
          m_out_pc = m_req_pc;
          m_out_in = m_req_in;
        end else begin
          m_out_v = 0;
        end
      end else if (m_arr) begin
        q_pc.push_back(m_req_pc);
        q_in.push_back(m_req_in);
      end
      if (m_arr && m_req_in[15:12] == 4'hF) m_halted = 1;
      m_req = m_iss;
      if (m_iss) begin
        m_req_pc = m_pc;
        m_req_in = mem[m_pc];
        m_pc = m_pc + 16'd1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("valid", {15'd0, valid}, {15'd0, m_out_v});
      chk("hlt", {15'd0, hlt}, {15'd0, m_halted});
      chk("imAddr", im_addr, m_pc);
      chk("imRdEn", {15'd0, im_rd},
          {15'd0, !m_halted && !stall && q_pc.size() == 0 && !redirect});
      if (m_out_v) begin
        chk("instr", instr, m_out_in);
        chk("pc", pc, m_out_pc);
        chk("pcPlus1", pcp1, m_out_pc + 16'd1);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic at(input int n);
    while (cyc < n) tick();
    #1;
  endtask

  task automatic drv_at(input int n);
    while (cyc < n) tick();
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 16'(16'h1000 + a);
    rst_n = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    target = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    #1;
    chk("rst valid", {15'd0, valid}, 16'd0);
    chk("rst hlt", {15'd0, hlt}, 16'd0);
    chk("rst imAddr", im_addr, 16'h0000);
    chk("rst imRdEn", {15'd0, im_rd}, 16'd1);
    chk("rst pc", pc, 16'h0000);
    chk("rst instr", instr, 16'h0000);
    chk("rst2 imAddr", im_addr2, 16'hFFFE);

    at(1);
    chk("c1 valid", {15'd0, valid}, 16'd0);
    at(2);
    chk("c2 valid", {15'd0, valid}, 16'd1);
    chk("c2 instr", instr, 16'h1000);
    chk("c2 pc", pc, 16'h0000);
    chk("c2 pcp1", pcp1, 16'h0001);
    chk("w2 instr", instr2, 16'h0FFE);
    chk("w2 pc", pc2, 16'hFFFE);
    chk("w2 pcp1", pcp12, 16'hFFFF);
    at(3);
    chk("c3 instr", instr, 16'h1001);
    chk("c3 pcp1", pcp1, 16'h0002);
    chk("w3 pc", pc2, 16'hFFFF);
    chk("w3 pcp1", pcp12, 16'h0000);
    at(4);
    chk("w4 pc", pc2, 16'h0000);
    chk("w4 pcp1", pcp12, 16'h0001);
    chk("w4 instr", instr2, 16'h1000);

    drv_at(6); stall = 1'b1; #1;
    chk("st6 instr", instr, 16'h1004);
    chk("st6 rd", {15'd0, im_rd}, 16'd0);
    at(8);
    chk("st8 instr", instr, 16'h1004);
    drv_at(9); stall = 1'b0; #1;
    chk("st9 instr", instr, 16'h1004);
    chk("st9 rd", {15'd0, im_rd}, 16'd0);
    at(10);
    chk("st10 instr", instr, 16'h1005);
    chk("st10 pc", pc, 16'h0005);
    at(11);
    chk("st11 bubble", {15'd0, valid}, 16'd0);
    at(12);
    chk("st12 instr", instr, 16'h1006);

    drv_at(14); redirect = 1'b1; target = 16'h0040; #1;
    chk("rd14 rd", {15'd0, im_rd}, 16'd0);
    drv_at(15); redirect = 1'b0; #1;
    chk("rd15 valid", {15'd0, valid}, 16'd0);
    chk("rd15 addr", im_addr, 16'h0040);
    at(16);
    chk("rd16 valid", {15'd0, valid}, 16'd0);
    at(17);
    chk("rd17 pc", pc, 16'h0040);
    chk("rd17 instr", instr, 16'h1040);
    at(18);
    chk("rd18 pc", pc, 16'h0041);

    drv_at(20); stall = 1'b1; redirect = 1'b1; target = 16'h0040;
    drv_at(21); stall = 1'b0; redirect = 1'b0; #1;
    chk("rs21 valid", {15'd0, valid}, 16'd0);
    at(22);
    chk("rs22 valid", {15'd0, valid}, 16'd0);
    at(23);
    chk("rs23 pc", pc, 16'h0040);
    at(24);
    chk("rs24 pc", pc, 16'h0041);

    drv_at(26); mem[3] = 16'hF000; redirect = 1'b1; target = 16'h0000;
    drv_at(27); redirect = 1'b0;
    at(31);
    chk("h31 pc", pc, 16'h0002);
    chk("h31 hlt", {15'd0, hlt}, 16'd0);
    at(32);
    chk("h32 instr", instr, 16'hF000);
    chk("h32 pc", pc, 16'h0003);
    chk("h32 hlt", {15'd0, hlt}, 16'd1);
    chk("h32 rd", {15'd0, im_rd}, 16'd0);
    at(33);
    chk("h33 valid", {15'd0, valid}, 16'd0);
    chk("h33 addr", im_addr, 16'h0005);
    at(35);
    chk("h35 valid", {15'd0, valid}, 16'd0);
    chk("h35 hlt", {15'd0, hlt}, 16'd1);
    drv_at(36); redirect = 1'b1; target = 16'h0010;
    drv_at(37); redirect = 1'b0; #1;
    chk("h37 hlt", {15'd0, hlt}, 16'd0);
    chk("h37 rd", {15'd0, im_rd}, 16'd1);
    chk("h37 addr", im_addr, 16'h0010);
    at(39);
    chk("h39 pc", pc, 16'h0010);
    chk("h39 instr", instr, 16'h1010);

    drv_at(42); stall = 1'b1;
    drv_at(43); rst_n = 1'b0;
    drv_at(44); rst_n = 1'b1; stall = 1'b0; #1;
    chk("r44 valid", {15'd0, valid}, 16'd0);
    chk("r44 hlt", {15'd0, hlt}, 16'd0);
    chk("r44 addr", im_addr, 16'h0000);
    at(45);
    chk("r45 valid", {15'd0, valid}, 16'd0);
    at(46);
    chk("r46 pc", pc, 16'h0000);
    chk("r46 instr", instr, 16'h1000);

    drv_at(52);
    mem[3] = 16'h1003;
    mem[16'h0080] = 16'hF080;
    for (int i = 0; i < 300; i++) begin
      stall = ($urandom_range(0, 2) == 0);
      redirect = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 3) == 0)
        target = 16'(16'hFFF8 + $urandom_range(0, 15));
      else
        target = 16'($urandom_range(0, 255));
      tick();
    end
    stall = 1'b0;
    redirect = 1'b0;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
